// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency-sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sweep_pkg;

  localparam int M_DEF  = 32;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Dwell down-counter: loadable, decrements to zero and holds there.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: none; zero flag is a plain compare of the count.
module dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [DW-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep controller: steps the phase-accumulator increment from f_start toward f_stop.
// Latency: start -> CLEAR (1 cycle) -> first p_step=f_start; each step held dwell+1 cycles.
// Backpressure: none; start while busy is ignored, abort returns to IDLE next cycle.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [M-1:0] f_start,
  input  logic signed [M-1:0] f_stop,
  input  logic signed [M-1:0] f_inc,
  input  logic [DW-1:0]       dwell,
  input  logic [1:0]          mode,
  output logic signed [M-1:0] p_step,
  output logic                acc_clr,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  state_t              state_q, state_d;
  logic signed [M-1:0] p_step_q, p_step_d;
  logic                dir_up_q, dir_up_d;
  logic                acc_clr_q, acc_clr_d;
  logic                cfg_err_q, cfg_err_d;

  // Configuration captured at start; later input changes are ignored.
  logic signed [M-1:0] f_start_q, f_stop_q;
  logic signed [M:0]   inc_mag_q;
  logic [DW-1:0]       dwell_q;
  logic [1:0]          mode_q;
  logic                base_up_q;
  logic                latch_cfg;

  logic                tmr_load, tmr_zero;
  logic [DW-1:0]       tmr_val;

  // Step arithmetic is done one bit wider so nothing wraps near full scale.
  logic signed [M:0]   f_inc_x, inc_mag_in;
  logic signed [M:0]   cur_x, start_x, stop_x, lo_x, hi_x, next_x;
  logic signed [M:0]   mirror_dn_x, mirror_up_x, turn_dn_x, turn_up_x;
  logic                pass_end, cfg_ok;

  assign f_inc_x    = {f_inc[M-1], f_inc};
  assign inc_mag_in = f_inc[M-1] ? -f_inc_x : f_inc_x;
  assign cfg_ok     = (f_inc != '0)
                   && !(!f_inc[M-1] && (f_stop < f_start))
                   && !( f_inc[M-1] && (f_stop > f_start));

  assign cur_x       = {p_step_q[M-1], p_step_q};
  assign start_x     = {f_start_q[M-1], f_start_q};
  assign stop_x      = {f_stop_q[M-1], f_stop_q};
  assign lo_x        = (start_x < stop_x) ? start_x : stop_x;
  assign hi_x        = (start_x < stop_x) ? stop_x : start_x;
  assign next_x      = dir_up_q ? (cur_x + inc_mag_q) : (cur_x - inc_mag_q);
  assign pass_end    = dir_up_q ? (next_x > hi_x) : (next_x < lo_x);
  // Triangle turnaround points, clamped so they never leave [lo, hi].
  assign mirror_dn_x = hi_x - inc_mag_q;
  assign mirror_up_x = lo_x + inc_mag_q;
  assign turn_dn_x   = (mirror_dn_x < lo_x) ? lo_x : mirror_dn_x;
  assign turn_up_x   = (mirror_up_x > hi_x) ? hi_x : mirror_up_x;

  dwell_timer #(.DW(DW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (state_q == ST_DWELL),
    .zero_o     (tmr_zero)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      p_step_q  <= '0;
      dir_up_q  <= 1'b1;
      acc_clr_q <= 1'b0;
      cfg_err_q <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      inc_mag_q <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_SINGLE;
      base_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      p_step_q  <= p_step_d;
      dir_up_q  <= dir_up_d;
      acc_clr_q <= acc_clr_d;
      cfg_err_q <= cfg_err_d;
      if (latch_cfg) begin
        f_start_q <= f_start;
        f_stop_q  <= f_stop;
        inc_mag_q <= inc_mag_in;
        dwell_q   <= dwell;
        mode_q    <= mode;
        base_up_q <= !f_inc[M-1];
      end
    end
  end

  // Next-state and step sequencing; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    p_step_d  = p_step_q;
    dir_up_d  = dir_up_q;
    acc_clr_d = 1'b0;
    cfg_err_d = 1'b0;
    latch_cfg = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = dwell_q;
    unique case (state_q)
      ST_IDLE: begin
        p_step_d = '0;
        if (start && !abort) begin
          if (cfg_ok) begin
            latch_cfg = 1'b1;
            acc_clr_d = 1'b1;
            state_d   = ST_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        p_step_d = f_start_q;
        dir_up_d = base_up_q;
        tmr_load = 1'b1;
        state_d  = ST_DWELL;
      end
      ST_DWELL: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (!pass_end) begin
            p_step_d = next_x[M-1:0];
          end else begin
            case (mode_q)
              MODE_REPEAT: begin
                p_step_d  = f_start_q;
                acc_clr_d = 1'b1;
              end
              MODE_TRI: begin
                dir_up_d = !dir_up_q;
                p_step_d = dir_up_q ? turn_dn_x[M-1:0] : turn_up_x[M-1:0];
              end
              default: state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_DONE: begin
        p_step_d = '0;
        tmr_load = 1'b1;
        tmr_val  = '0;
        state_d  = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      p_step_d  = '0;
      acc_clr_d = 1'b0;
      tmr_load  = 1'b1;
      tmr_val   = '0;
    end
  end

  // Outputs: registered step/clear/error, status decoded from state.
  always_comb begin
    p_step  = p_step_q;
    acc_clr = acc_clr_q;
    cfg_err = cfg_err_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait is a fixed cycle count.
module tb_sweep_ctrl;
  import sweep_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic signed [31:0] f_start = '0;
  logic signed [31:0] f_stop = '0;
  logic signed [31:0] f_inc = '0;
  logic [15:0]        dwell = '0;
  logic [1:0]         mode = '0;
  logic signed [31:0] p_step;
  logic               acc_clr, busy, done, cfg_err;

  int checks = 0;
  int failures = 0;

  sweep_ctrl #(.M(32), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_inc(f_inc),
    .dwell(dwell), .mode(mode),
    .p_step(p_step), .acc_clr(acc_clr), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Presents a configuration with a one-cycle start; returns one cycle later.
  task automatic kick(input logic signed [31:0] s, input logic signed [31:0] e,
                      input logic signed [31:0] inc, input logic [15:0] dw,
                      input logic [1:0] md, input logic ab);
    @(negedge clk);
    f_start = s; f_stop = e; f_inc = inc; dwell = dw; mode = md;
    abort = ab; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; f_start = 5; f_stop = 9; f_inc = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, acc_clr, cfg_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, acc_clr, cfg_err});
    end
    checks++;
    if (p_step !== 0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p_step); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int exp_p;
    kick(10, 40, 10, 2, MODE_SINGLE, 1'b0);
    f_start = -5; f_stop = 1000; f_inc = 3; dwell = 7; mode = MODE_TRI;
    checks++;
    if ({busy, acc_clr, done} !== 3'b110 || p_step !== 0) begin
      failures++; $display("FAIL single_clear got=%b p=%0d exp=110 p=0", {busy, acc_clr, done}, p_step);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_p = 10 + 10 * (i / 3);
      checks++;
      if (p_step !== exp_p || {busy, done, acc_clr} !== 3'b100) begin
        failures++; $display("FAIL single_step[%0d] got p=%0d f=%b exp p=%0d f=100", i, p_step, {busy, done, acc_clr}, exp_p);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_step !== 40) begin
      failures++; $display("FAIL single_done got done=%b p=%0d exp done=1 p=40", done, p_step);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || p_step !== 0) begin
      failures++; $display("FAIL single_idle got=%b p=%0d exp=00 p=0", {busy, done}, p_step);
    end
  endtask

  task automatic test_descending();
    kick(100, 75, -10, 0, MODE_SINGLE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (p_step !== 100 - 10 * i || done !== 1'b0) begin
        failures++; $display("FAIL desc_step[%0d] got p=%0d done=%b exp p=%0d done=0", i, p_step, done, 100 - 10 * i);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_step !== 80) begin
      failures++; $display("FAIL desc_done got done=%b p=%0d exp done=1 p=80", done, p_step);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || p_step !== 0) begin
      failures++; $display("FAIL desc_idle got busy=%b p=%0d exp busy=0 p=0", busy, p_step);
    end
  endtask

  task automatic test_repeat();
    int  exp_p;
    logic exp_acc;
    kick(0, 20, 10, 0, MODE_REPEAT, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_p = (i % 3) * 10;
      exp_acc = ((i % 3) == 0) && (i > 0);
      checks++;
      if (p_step !== exp_p || acc_clr !== exp_acc || done !== 1'b0) begin
        failures++; $display("FAIL repeat_step[%0d] got p=%0d clr=%b done=%b exp p=%0d clr=%b done=0", i, p_step, acc_clr, done, exp_p, exp_acc);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, acc_clr} !== 3'b000 || p_step !== 0) begin
      failures++; $display("FAIL repeat_abort got=%b p=%0d exp=000 p=0", {busy, done, acc_clr}, p_step);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL repeat_no_done got=%b exp=0", done); end
  endtask

  task automatic test_triangle();
    int exp_tab [12] = '{0, 10, 20, 30, 20, 10, 0, 10, 20, 30, 20, 10};
    kick(0, 30, 10, 0, MODE_TRI, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (p_step !== exp_tab[i] || {busy, done} !== 2'b10) begin
        failures++; $display("FAIL tri_step[%0d] got p=%0d f=%b exp p=%0d f=10", i, p_step, {busy, done}, exp_tab[i]);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || p_step !== 0) begin
      failures++; $display("FAIL tri_abort got busy=%b p=%0d exp busy=0 p=0", busy, p_step);
    end
  endtask

  task automatic test_cfg_err();
    int bs [3] = '{5, 20, 20};
    int be [3] = '{9, 10, 30};
    int bi [3] = '{0, 1, -1};
    for (int k = 0; k < 3; k++) begin
      kick(bs[k], be[k], bi[k], 1, MODE_SINGLE, 1'b0);
      checks++;
      if ({cfg_err, busy} !== 2'b10) begin
        failures++; $display("FAIL cfg_err_pulse[%0d] got=%b exp=10", k, {cfg_err, busy});
      end
      @(negedge clk);
      checks++;
      if ({cfg_err, busy} !== 2'b00) begin
        failures++; $display("FAIL cfg_err_clear[%0d] got=%b exp=00", k, {cfg_err, busy});
      end
    end
  endtask

  task automatic test_overflow();
    kick(32'sh7FFFFFF0, 32'sh7FFFFFFF, 16, 0, MODE_SINGLE, 1'b0);
    @(negedge clk);
    checks++;
    if (p_step !== 32'sh7FFFFFF0) begin
      failures++; $display("FAIL ovf_first got=%h exp=7ffffff0", p_step);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_step !== 32'sh7FFFFFF0) begin
      failures++; $display("FAIL ovf_done got done=%b p=%h exp done=1 p=7ffffff0", done, p_step);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || p_step !== 0) begin
      failures++; $display("FAIL ovf_idle got busy=%b p=%h exp busy=0 p=0", busy, p_step);
    end
  endtask

  task automatic test_rst_mid();
    kick(10, 40, 10, 2, MODE_SINGLE, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, acc_clr} !== 3'b000 || p_step !== 0) begin
      failures++; $display("FAIL rst_mid got=%b p=%0d exp=000 p=0", {busy, done, acc_clr}, p_step);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++; $display("FAIL rst_mid_after[%0d] got=%b exp=00", i, {busy, done});
      end
    end
  endtask

  task automatic test_start_abort();
    kick(10, 40, 10, 2, MODE_SINGLE, 1'b1);
    checks++;
    if ({busy, acc_clr, cfg_err} !== 3'b000) begin
      failures++; $display("FAIL start_abort got=%b exp=000", {busy, acc_clr, cfg_err});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_later got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    kick(0, 20, 10, 0, MODE_SINGLE, 1'b0);
    @(negedge clk);
    f_start = 5; f_stop = 6; f_inc = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (p_step !== 10 || acc_clr !== 1'b0) begin
      failures++; $display("FAIL busy_start_ignored got p=%0d clr=%b exp p=10 clr=0", p_step, acc_clr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_step !== 20) begin
      failures++; $display("FAIL b2b_first_done got done=%b p=%0d exp done=1 p=20", done, p_step);
    end
    kick(5, 6, 1, 0, MODE_SINGLE, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (p_step !== 5 + i) begin
        failures++; $display("FAIL b2b_second[%0d] got=%0d exp=%0d", i, p_step, 5 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_descending();
    test_repeat();
    test_triangle();
    test_cfg_err();
    test_overflow();
    test_rst_mid();
    test_start_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
